scv_bus_waitgen: RTL and testbench

External-bus decoder and wait-state generator for the uPD7801 core in the SCV design. It decodes the CPU address into one of NUM_REGIONS chip selects and multiplexes the selected device's read data back to the CPU. It holds WAITB low for a per-region number of CPU states, settable by parameter or overridden at run time. It is the parametrised, synthesizable successor to the fixed one-state wait used in CPU-level simulation.

---
 rtl/scv_bus_waitgen.sv | 153 +++++++++++++++
 tb/tb_scv_bus_waitgen.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scv_bus_waitgen.sv
// External-bus decoder and wait-state generator for the uPD7801 core.
// Decodes chip selects, muxes device read data, and stretches CPU states via WAITB.
module scv_bus_waitgen #(
  parameter int NUM_REGIONS = 2,
  parameter int AW          = 16,
  parameter int DW          = 8,
  parameter int WAIT_W      = 3,
  parameter logic [NUM_REGIONS*AW-1:0]     REGION_BASE = {16'h8000, 16'h0000},
  parameter logic [NUM_REGIONS*AW-1:0]     REGION_MASK = {16'h8000, 16'h8000},
  parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT = {3'd0, 3'd1}
) (
  input  logic                    CLK,
  input  logic                    RESETB,
  input  logic                    CP1_POSEDGE,
  input  logic [AW-1:0]           A,
  input  logic                    A_OE,
  input  logic                    RDB,
  input  logic                    WRB,
  input  logic [NUM_REGIONS*DW-1:0] DEV_DB,
  output logic [DW-1:0]           DB_O,
  output logic [NUM_REGIONS-1:0]  CS_N,
  output logic                    WAITB,
  input  logic                    WAIT_OVR_WE,
  input  logic [2:0]              WAIT_OVR_IDX,
  input  logic [WAIT_W:0]         WAIT_OVR_VAL,
  output logic                    BUS_ERR,
  output logic                    dbg_state
);

  localparam int SW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  // Handshake: a CPU access is the strobe (~RDB | ~WRB) seen on CP1_POSEDGE;
  // WAITB low holds the CPU in its current state until the count expires.

  logic [NUM_REGIONS-1:0] hit;
  logic                   any_hit;
  logic [SW-1:0]          sel;
  logic [DW-1:0]          rd_data;
  logic [WAIT_W-1:0]      eff_wait;
  logic [WAIT_W:0]        ovr [NUM_REGIONS];

  logic                   strobe;
  logic                   strobe_q;
  logic                   start;

  state_t                 state, state_n;
  logic [WAIT_W-1:0]      cnt, cnt_n;
  logic                   waitb_q, waitb_n;
  logic                   bus_err_q, bus_err_n;

  always_comb begin
    hit      = '0;
    any_hit  = 1'b0;
    sel      = '0;
    CS_N     = '1;
    rd_data  = '1;
    eff_wait = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      hit[i] = A_OE && ((A & REGION_MASK[i*AW +: AW]) == REGION_BASE[i*AW +: AW]);
    end
    // Lowest-index hit wins.
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (hit[i] && !any_hit) begin
        any_hit = 1'b1;
        sel     = SW'(i);
        CS_N[i] = 1'b0;
      end
    end
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (sel == SW'(i)) begin
        rd_data  = DEV_DB[i*DW +: DW];
        eff_wait = ovr[i][WAIT_W] ? ovr[i][WAIT_W-1:0] : REGION_WAIT[i*WAIT_W +: WAIT_W];
      end
    end
    DB_O = (!RDB && any_hit) ? rd_data : '1;
  end

  // Override table is written on any CLK; out-of-range indices match no entry.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      for (int i = 0; i < NUM_REGIONS; i++) ovr[i] <= '0;
    end else if (WAIT_OVR_WE) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (WAIT_OVR_IDX == 3'(i)) ovr[i] <= WAIT_OVR_VAL;
      end
    end
  end

  assign strobe = ~RDB | ~WRB;
  assign start  = CP1_POSEDGE & strobe & ~strobe_q;

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      strobe_q <= 1'b0;
    end else if (CP1_POSEDGE) begin
      strobe_q <= strobe;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    waitb_n   = waitb_q;
    bus_err_n = start && !any_hit;
    case (state)
      ST_IDLE: begin
        if (start && any_hit && (eff_wait != '0)) begin
          cnt_n   = eff_wait;
          waitb_n = 1'b0;
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (CP1_POSEDGE) begin
          // Release on the edge where the count was 1, or abort if the strobe dropped.
          if (!strobe || (cnt == WAIT_W'(1))) begin
            cnt_n   = '0;
            waitb_n = 1'b1;
            state_n = ST_IDLE;
          end else begin
            cnt_n = cnt - WAIT_W'(1);
          end
        end
      end
      default: begin
        cnt_n   = '0;
        waitb_n = 1'b1;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      waitb_q   <= 1'b1;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      waitb_q   <= waitb_n;
      bus_err_q <= bus_err_n;
    end
  end

  assign WAITB     = waitb_q;
  assign BUS_ERR   = bus_err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_scv_bus_waitgen.sv
// Bench for scv_bus_waitgen: decode, read mux, wait lengths, overrides, abort, reset.
module tb_scv_bus_waitgen;

  logic        CLK = 1'b0;
  logic        RESETB = 1'b0;
  logic        CP1_POSEDGE = 1'b0;
  logic [15:0] A = '0;
  logic        A_OE = 1'b0;
  logic        RDB = 1'b1;
  logic        WRB = 1'b1;
  logic [15:0] DEV_DB = 16'hB2A1;
  logic [7:0]  DEV_DB1 = 8'h5C;
  logic        WAIT_OVR_WE = 1'b0;
  logic [2:0]  WAIT_OVR_IDX = '0;
  logic [3:0]  WAIT_OVR_VAL = '0;

  logic [7:0]  DB_O, DB_O1;
  logic [1:0]  CS_N;
  logic [0:0]  CS_N1;
  logic        WAITB, WAITB1, BUS_ERR, BUS_ERR1, dbg_state, dbg_state1;

  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];

  scv_bus_waitgen dut (
    .CLK(CLK), .RESETB(RESETB), .CP1_POSEDGE(CP1_POSEDGE), .A(A), .A_OE(A_OE),
    .RDB(RDB), .WRB(WRB), .DEV_DB(DEV_DB), .DB_O(DB_O), .CS_N(CS_N), .WAITB(WAITB),
    .WAIT_OVR_WE(WAIT_OVR_WE), .WAIT_OVR_IDX(WAIT_OVR_IDX), .WAIT_OVR_VAL(WAIT_OVR_VAL),
    .BUS_ERR(BUS_ERR), .dbg_state(dbg_state)
  );

  scv_bus_waitgen #(
    .NUM_REGIONS(1), .REGION_BASE(16'h0000), .REGION_MASK(16'h8000), .REGION_WAIT(3'd1)
  ) dut1 (
    .CLK(CLK), .RESETB(RESETB), .CP1_POSEDGE(CP1_POSEDGE), .A(A), .A_OE(A_OE),
    .RDB(RDB), .WRB(WRB), .DEV_DB(DEV_DB1), .DB_O(DB_O1), .CS_N(CS_N1), .WAITB(WAITB1),
    .WAIT_OVR_WE(WAIT_OVR_WE), .WAIT_OVR_IDX(WAIT_OVR_IDX), .WAIT_OVR_VAL(WAIT_OVR_VAL),
    .BUS_ERR(BUS_ERR1), .dbg_state(dbg_state1)
  );

  // Clock and CPU-state enable: one CLK-wide CP1_POSEDGE every 4 CLKs.
  always #5 CLK = ~CLK;

  initial begin
    forever begin
      repeat (3) @(posedge CLK);
      #1 CP1_POSEDGE = 1'b1;
      @(posedge CLK);
      #1 CP1_POSEDGE = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Returns 2 time units after the next CLK edge that carries CP1_POSEDGE.
  task automatic wait_cp1();
    do @(posedge CLK); while (!CP1_POSEDGE);
    #2;
  endtask

  task automatic ovr_write(input logic [2:0] idx, input logic [3:0] val);
    @(negedge CLK);
    WAIT_OVR_WE  = 1'b1;
    WAIT_OVR_IDX = idx;
    WAIT_OVR_VAL = val;
    @(negedge CLK);
    WAIT_OVR_WE  = 1'b0;
  endtask

  task automatic measure_wait(output int n);
    n = 0;
    while (WAITB === 1'b0 && n < 20) begin
      wait_cp1();
      n++;
    end
  endtask

  task automatic do_access(input logic [15:0] addr, input logic is_write,
                           input logic [1:0] exp_cs, input logic [7:0] exp_db,
                           input logic [3:0] exp_wait, input string name);
    int n;
    logic [3:0] exp;
    A = addr;
    A_OE = 1'b1;
    wait_cp1();
    if (is_write) WRB = 1'b0;
    else RDB = 1'b0;
    #1;
    total++;
    if (CS_N !== exp_cs) begin
      bad++;
      $display("FAIL %s_cs: got %b want %b", name, CS_N, exp_cs);
    end
    total++;
    if (DB_O !== exp_db) begin
      bad++;
      $display("FAIL %s_db: got %h want %h", name, DB_O, exp_db);
    end
    exp_q.push_back(exp_wait);
    wait_cp1();
    measure_wait(n);
    exp = exp_q.pop_front();
    total++;
    if (n != int'(exp)) begin
      bad++;
      $display("FAIL %s_wait: got %0d states want %0d", name, n, exp);
    end
    RDB = 1'b1;
    WRB = 1'b1;
    wait_cp1();
    A_OE = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (WAITB !== 1'b1) begin bad++; $display("FAIL reset_waitb: got %b want 1", WAITB); end
    total++;
    if (BUS_ERR !== 1'b0) begin bad++; $display("FAIL reset_bus_err: got %b want 0", BUS_ERR); end
    total++;
    if (CS_N !== 2'b11) begin bad++; $display("FAIL reset_cs: got %b want 11", CS_N); end
    total++;
    if (DB_O !== 8'hFF) begin bad++; $display("FAIL reset_db: got %h want ff", DB_O); end
    total++;
    if (dbg_state !== 1'b0) begin bad++; $display("FAIL reset_state: got %b want 0", dbg_state); end
    @(negedge CLK);
    RESETB = 1'b1;
    wait_cp1();
  endtask

  task automatic test_default_decode();
    do_access(16'h0123, 1'b0, 2'b10, 8'hA1, 4'd1, "dec_r0");
    do_access(16'h8000, 1'b0, 2'b01, 8'hB2, 4'd0, "dec_r1");
  endtask

  task automatic test_back_to_back();
    do_access(16'h0123, 1'b0, 2'b10, 8'hA1, 4'd1, "b2b_a");
    do_access(16'h0456, 1'b1, 2'b10, 8'hFF, 4'd1, "b2b_wr");
    do_access(16'hFFFF, 1'b0, 2'b01, 8'hB2, 4'd0, "b2b_b");
  endtask

  task automatic test_override();
    ovr_write(3'd1, 4'b1101);
    do_access(16'h8000, 1'b0, 2'b01, 8'hB2, 4'd5, "ovr_5");
    ovr_write(3'd1, 4'b0000);
    do_access(16'h8000, 1'b0, 2'b01, 8'hB2, 4'd0, "ovr_off");
    ovr_write(3'd5, 4'b1111);
    do_access(16'h0123, 1'b0, 2'b10, 8'hA1, 4'd1, "ovr_badidx");
  endtask

  task automatic test_abort();
    ovr_write(3'd0, 4'b1111);
    A = 16'h0123;
    A_OE = 1'b1;
    wait_cp1();
    RDB = 1'b0;
    wait_cp1();
    wait_cp1();
    wait_cp1();
    total++;
    if (WAITB !== 1'b0 || dbg_state !== 1'b1) begin
      bad++;
      $display("FAIL abort_mid: got waitb=%b state=%b want 0/1", WAITB, dbg_state);
    end
    RDB = 1'b1;
    wait_cp1();
    total++;
    if (WAITB !== 1'b1 || dbg_state !== 1'b0) begin
      bad++;
      $display("FAIL abort_release: got waitb=%b state=%b want 1/0", WAITB, dbg_state);
    end
    do_access(16'h0123, 1'b0, 2'b10, 8'hA1, 4'd7, "abort_next");
    ovr_write(3'd0, 4'b0000);
  endtask

  task automatic test_no_hit();
    A = 16'hC000;
    A_OE = 1'b1;
    wait_cp1();
    RDB = 1'b0;
    #1;
    total++;
    if (CS_N1 !== 1'b1 || DB_O1 !== 8'hFF) begin
      bad++;
      $display("FAIL nohit_decode: got cs=%b db=%h want 1/ff", CS_N1, DB_O1);
    end
    wait_cp1();
    total++;
    if (BUS_ERR1 !== 1'b1 || WAITB1 !== 1'b1) begin
      bad++;
      $display("FAIL nohit_err: got bus_err=%b waitb=%b want 1/1", BUS_ERR1, WAITB1);
    end
    total++;
    if (BUS_ERR !== 1'b0) begin bad++; $display("FAIL hit_no_err: got %b want 0", BUS_ERR); end
    @(posedge CLK);
    #2;
    total++;
    if (BUS_ERR1 !== 1'b0) begin bad++; $display("FAIL nohit_pulse: got %b want 0", BUS_ERR1); end
    RDB = 1'b1;
    wait_cp1();
    A = 16'h0123;
    A_OE = 1'b0;
    wait_cp1();
    RDB = 1'b0;
    #1;
    total++;
    if (CS_N !== 2'b11 || DB_O !== 8'hFF) begin
      bad++;
      $display("FAIL noaoe_decode: got cs=%b db=%h want 11/ff", CS_N, DB_O);
    end
    wait_cp1();
    total++;
    if (BUS_ERR !== 1'b1 || WAITB !== 1'b1) begin
      bad++;
      $display("FAIL noaoe_err: got bus_err=%b waitb=%b want 1/1", BUS_ERR, WAITB);
    end
    RDB = 1'b1;
    wait_cp1();
  endtask

  task automatic test_async_reset();
    ovr_write(3'd0, 4'b1011);
    A = 16'h0123;
    A_OE = 1'b1;
    wait_cp1();
    RDB = 1'b0;
    wait_cp1();
    wait_cp1();
    total++;
    if (WAITB !== 1'b0) begin bad++; $display("FAIL areset_pre: got %b want 0", WAITB); end
    #3;
    RESETB = 1'b0;
    #1;
    total++;
    if (WAITB !== 1'b1 || dbg_state !== 1'b0) begin
      bad++;
      $display("FAIL areset_async: got waitb=%b state=%b want 1/0", WAITB, dbg_state);
    end
    RDB = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESETB = 1'b1;
    wait_cp1();
    do_access(16'h0123, 1'b0, 2'b10, 8'hA1, 4'd1, "areset_dflt");
  endtask

  task automatic test_held_strobe();
    int low;
    logic [3:0] exp;
    ovr_write(3'd0, 4'b1010);
    A = 16'h0123;
    A_OE = 1'b1;
    wait_cp1();
    RDB = 1'b0;
    exp_q.push_back(4'd2);
    wait_cp1();
    low = (WAITB === 1'b0) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      wait_cp1();
      if (WAITB === 1'b0) low++;
    end
    exp = exp_q.pop_front();
    total++;
    if (low != int'(exp)) begin
      bad++;
      $display("FAIL held_low: got %0d states want %0d", low, exp);
    end
    total++;
    if (WAITB !== 1'b1) begin bad++; $display("FAIL held_end: got %b want 1", WAITB); end
    RDB = 1'b1;
    wait_cp1();
    A_OE = 1'b0;
    ovr_write(3'd0, 4'b0000);
  endtask

  initial begin
    test_reset();
    test_default_decode();
    test_back_to_back();
    test_override();
    test_abort();
    test_no_hit();
    test_async_reset();
    test_held_strobe();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_empty: got %0d entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
